empacotador_imediato: RTL and testbench

Immediate packer for the MIPS-style datapath's instruction-memory loader, working in the opposite direction to the immediate sign extender. It accepts a 32-bit signed value, a field selector and a base instruction word. It checks that the value is representable in the selected immediate field (17, 22 or 18 bits, signed), inserts the truncated field into the base word, and writes the result to instruction memory at an auto-incrementing address. Values that do not fit are dropped and recorded in sticky error status.

---
 rtl/pacote_mips.sv | 30 +++
 rtl/empacotador_imediato_if.sv | 27 ++
 rtl/empacotador_imediato_verifica_faixa.sv | 23 ++
 rtl/empacotador_imediato.sv | 134 +++++++++++++
 tb/tb_empacotador_imediato.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pacote_mips.sv
// Shared definitions for the MIPS-style immediate fields, used by the packer and the
// sign extender so both decode the same selector values and field widths.
package pacote_mips;

    localparam logic [1:0] SEL_IMM17    = 2'b00;
    localparam logic [1:0] SEL_IMM22    = 2'b01;
    localparam logic [1:0] SEL_IMM18    = 2'b10;
    localparam logic [1:0] SEL_INVALIDA = 2'b11;

    localparam int unsigned LARG_IMM17     = 17;
    localparam int unsigned LARG_IMM22     = 22;
    localparam int unsigned LARG_IMM18     = 18;
    localparam int unsigned LARG_CAMPO_MAX = 22;

    typedef enum logic [1:0] {
        Ocioso,
        Verifica,
        Escreve
    } estado_t;

    // The invalid selector maps to the widest field; callers reject it separately.
    function automatic int unsigned largura_campo(input logic [1:0] sel);
        case (sel)
            SEL_IMM17: return LARG_IMM17;
            SEL_IMM18: return LARG_IMM18;
            default:   return LARG_IMM22;
        endcase
    endfunction

endpackage

// File: rtl/empacotador_imediato_if.sv
// Request and instruction-memory side signals of the immediate packer.
interface empacotador_imediato_if #(
    parameter int unsigned LARGURA_END = 10
);
    logic                   entrada_valida;
    logic                   pronto;
    logic [1:0]             selecao;
    logic [31:0]            valor;
    logic [31:0]            palavra_base;
    logic                   limpar_erro;
    logic                   mem_escrita;
    logic [LARGURA_END-1:0] mem_endereco;
    logic [31:0]            mem_dado;
    logic                   erro;
    logic [7:0]             cont_erros;
    logic                   memoria_cheia;

    modport master (
        output entrada_valida, selecao, valor, palavra_base, limpar_erro,
        input  pronto, mem_escrita, mem_endereco, mem_dado, erro, cont_erros, memoria_cheia
    );

    modport slave (
        input  entrada_valida, selecao, valor, palavra_base, limpar_erro,
        output pronto, mem_escrita, mem_endereco, mem_dado, erro, cont_erros, memoria_cheia
    );
endinterface

// File: rtl/empacotador_imediato_verifica_faixa.sv
// Combinational range check: does the signed value fit the selected immediate field,
// and what are its low bits truncated to that field (zero-filled to 22 bits).
module verifica_faixa
    import pacote_mips::*;
(
    input  logic [1:0]                selecao,
    input  logic [31:0]               valor,
    output logic                      cabe,
    output logic [LARG_CAMPO_MAX-1:0] campo
);
    int unsigned largura;
    logic [31:0] topo;
    logic [31:0] mascara;

    always_comb begin
        largura = largura_campo(selecao);
        // Bits [31:N-1] collapse to all-zeros or all-ones exactly when the value fits.
        topo    = 32'($signed(valor) >>> (largura - 1));
        cabe    = (selecao != SEL_INVALIDA) && ((topo == '0) || (topo == '1));
        mascara = (32'd1 << largura) - 32'd1;
        campo   = LARG_CAMPO_MAX'(valor & mascara);
    end
endmodule

// File: rtl/empacotador_imediato.sv
// Immediate packer: range-checks a signed value, inserts it into a base instruction word
// and writes the result to instruction memory at an auto-incrementing address.
module empacotador_imediato
    import pacote_mips::*;
#(
    parameter int unsigned LARGURA_END = 10,
    parameter int unsigned END_INICIAL = 0
) (
    input logic                   clock,
    input logic                   reset,
    empacotador_imediato_if.slave bus
);
    localparam logic [LARGURA_END-1:0] END_RESET = LARGURA_END'(END_INICIAL);
    localparam logic [LARGURA_END-1:0] END_FINAL = '1;

    estado_t                   estado_q, estado_d;
    logic [1:0]                sel_q;
    logic [31:0]               valor_q, base_q;
    logic                      escrita_q, escrita_d;
    logic                      rejeita_q, rejeita_d;
    logic [31:0]               dado_q;
    logic [LARGURA_END-1:0]    endereco_q, endereco_d;
    logic                      erro_q, erro_d;
    logic [7:0]                cont_q, cont_d;
    logic                      cheia_q, cheia_d;
    logic                      captura;
    logic                      cabe;
    logic [LARG_CAMPO_MAX-1:0] campo;
    logic [31:0]               mascara;
    logic [31:0]               palavra;
    logic                      aceita;

    verifica_faixa u_verifica_faixa (
        .selecao (sel_q),
        .valor   (valor_q),
        .cabe    (cabe),
        .campo   (campo)
    );

    always_comb begin
        mascara = (32'd1 << largura_campo(sel_q)) - 32'd1;
        palavra = (base_q & ~mascara) | {{(32 - LARG_CAMPO_MAX){1'b0}}, campo};
        // memoria_cheia only changes when ESCREVE ends, so deciding here is equivalent.
        aceita  = cabe && (sel_q != SEL_INVALIDA) && !cheia_q;
    end

    always_comb begin
        estado_d  = estado_q;
        captura   = 1'b0;
        escrita_d = 1'b0;
        rejeita_d = 1'b0;
        unique case (estado_q)
            Ocioso: begin
                if (bus.entrada_valida) begin
                    captura  = 1'b1;
                    estado_d = Verifica;
                end
            end
            Verifica: begin
                escrita_d = aceita;
                rejeita_d = !aceita;
                estado_d  = Escreve;
            end
            Escreve: estado_d = Ocioso;
            default: estado_d = Ocioso;
        endcase
    end

    always_comb begin
        erro_d     = erro_q;
        cont_d     = cont_q;
        endereco_d = endereco_q;
        cheia_d    = cheia_q;
        if (bus.limpar_erro) begin
            erro_d = 1'b0;
            cont_d = 8'd0;
        end
        // A reject in the same cycle as a clear is applied after it, so it wins.
        if (estado_q == Escreve) begin
            if (escrita_q) begin
                if (endereco_q == END_FINAL) begin
                    cheia_d = 1'b1;
                end else begin
                    endereco_d = endereco_q + 1'b1;
                end
            end else if (rejeita_q) begin
                erro_d = 1'b1;
                if (cont_d != 8'hFF) begin
                    cont_d = cont_d + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q   <= Ocioso;
            sel_q      <= SEL_IMM17;
            valor_q    <= '0;
            base_q     <= '0;
            escrita_q  <= 1'b0;
            rejeita_q  <= 1'b0;
            dado_q     <= '0;
            endereco_q <= END_RESET;
            erro_q     <= 1'b0;
            cont_q     <= 8'd0;
            cheia_q    <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            escrita_q  <= escrita_d;
            rejeita_q  <= rejeita_d;
            endereco_q <= endereco_d;
            erro_q     <= erro_d;
            cont_q     <= cont_d;
            cheia_q    <= cheia_d;
            if (captura) begin
                sel_q   <= bus.selecao;
                valor_q <= bus.valor;
                base_q  <= bus.palavra_base;
            end
            if (escrita_d) begin
                dado_q <= palavra;
            end
        end
    end

    assign bus.pronto        = (estado_q == Ocioso);
    assign bus.mem_escrita   = escrita_q;
    assign bus.mem_endereco  = endereco_q;
    assign bus.mem_dado      = dado_q;
    assign bus.erro          = erro_q;
    assign bus.cont_erros    = cont_q;
    assign bus.memoria_cheia = cheia_q;
endmodule

// File: tb/tb_empacotador_imediato.sv
// Randomized self-checking bench: two packers (10-bit and 2-bit address) share one request
// stream and are compared every cycle against a transaction-level reference model.
module tb_empacotador_imediato;

    typedef struct {
        logic [1:0]  sel;
        logic [31:0] val;
        logic [31:0] base;
        bit          limpa;
        bit          rst;
    } item_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        valid;
    logic        limpar;
    logic [1:0]  sel;
    logic [31:0] val;
    logic [31:0] base;

    int checks = 0;
    int erros  = 0;

    empacotador_imediato_if #(.LARGURA_END(10)) ia ();
    empacotador_imediato_if #(.LARGURA_END(2))  ib ();

    assign ia.entrada_valida = valid;
    assign ia.selecao        = sel;
    assign ia.valor          = val;
    assign ia.palavra_base   = base;
    assign ia.limpar_erro    = limpar;
    assign ib.entrada_valida = valid;
    assign ib.selecao        = sel;
    assign ib.valor          = val;
    assign ib.palavra_base   = base;
    assign ib.limpar_erro    = limpar;

    empacotador_imediato #(.LARGURA_END(10), .END_INICIAL(0)) dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (ia)
    );

    empacotador_imediato #(.LARGURA_END(2), .END_INICIAL(0)) dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (ib)
    );

    always #5 clock = ~clock;

    // Reference model: phase of the in-flight request (0 idle, 1 checking, 2 writing).
    item_t       fila[$];
    item_t       cur;
    int          fase;
    bit          rst_ext;
    bit          modo_alea;
    int          larg_end[2] = '{10, 2};
    logic [31:0] m_addr[2];
    logic [31:0] m_dado[2];
    bit          m_cheia[2];
    bit          m_erro[2];
    int          m_cont[2];
    bit          m_acc[2];
    bit          m_posrst[2];

    task automatic checar(input string tag, input logic [31:0] obtido, input logic [31:0] esperado);
        checks++;
        if (obtido !== esperado) begin
            erros++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obtido, esperado, $time);
        end
    endtask

    function automatic int largura_ref(input logic [1:0] s);
        return (s == 2'b00) ? 17 : (s == 2'b01) ? 22 : 18;
    endfunction

    function automatic bit cabe_ref(input logic [1:0] s, input logic [31:0] v);
        longint lim;
        longint x;
        if (s == 2'b11) return 1'b0;
        lim = longint'(1) << (largura_ref(s) - 1);
        x   = longint'($signed(v));
        return (x >= -lim) && (x < lim);
    endfunction

    function automatic logic [31:0] palavra_ref(input logic [1:0] s, input logic [31:0] v,
                                                input logic [31:0] b);
        longint m;
        m = (longint'(1) << largura_ref(s)) - 1;
        return 32'((longint'(b) & ~m) | (longint'(v) & m));
    endfunction

    function automatic logic [31:0] valor_alea(input logic [1:0] s);
        int lim;
        lim = 1 << (largura_ref(s) - 1);
        case ($urandom_range(0, 5))
            0:       return 32'(lim - 1);
            1:       return 32'(-lim);
            2:       return 32'(lim);
            3:       return 32'(-lim - 1);
            4:       return $urandom;
            default: return 32'(int'($urandom_range(0, 2 * lim - 1)) - lim);
        endcase
    endfunction

    task automatic modelo_reset();
        fase = 0;
        for (int d = 0; d < 2; d++) begin
            m_addr[d]   = 0;
            m_dado[d]   = 0;
            m_cheia[d]  = 0;
            m_erro[d]   = 0;
            m_cont[d]   = 0;
            m_acc[d]    = 0;
            m_posrst[d] = 1;
        end
    endtask

    task automatic checar_saidas();
        logic        o_pronto, o_esc, o_erro, o_cheia;
        logic [31:0] o_addr, o_dado, o_cont;
        for (int d = 0; d < 2; d++) begin
            if (d == 0) begin
                o_pronto = ia.pronto; o_esc = ia.mem_escrita; o_erro = ia.erro;
                o_cheia = ia.memoria_cheia; o_addr = 32'(ia.mem_endereco);
                o_dado = ia.mem_dado; o_cont = 32'(ia.cont_erros);
            end else begin
                o_pronto = ib.pronto; o_esc = ib.mem_escrita; o_erro = ib.erro;
                o_cheia = ib.memoria_cheia; o_addr = 32'(ib.mem_endereco);
                o_dado = ib.mem_dado; o_cont = 32'(ib.cont_erros);
            end
            checar($sformatf("d%0d_pronto", d), 32'(o_pronto), 32'(fase == 0));
            checar($sformatf("d%0d_escrita", d), 32'(o_esc), 32'(fase == 2 && m_acc[d]));
            checar($sformatf("d%0d_dado", d), o_dado, m_dado[d]);
            checar($sformatf("d%0d_erro", d), 32'(o_erro), 32'(m_erro[d]));
            checar($sformatf("d%0d_cont", d), o_cont, 32'(m_cont[d]));
            checar($sformatf("d%0d_cheia", d), 32'(o_cheia), 32'(m_cheia[d]));
            if ((fase == 2 && m_acc[d]) || m_posrst[d]) begin
                checar($sformatf("d%0d_endereco", d), o_addr, m_addr[d]);
            end
        end
    endtask

    task automatic escolher();
        reset  = rst_ext || (fase == 1 && cur.rst);
        limpar = (fase == 2 && cur.limpa) || (modo_alea && $urandom_range(0, 19) == 0);
        if (fase == 0 && fila.size() != 0 && !(modo_alea && $urandom_range(0, 3) == 0)) begin
            valid = 1'b1;
            sel   = fila[0].sel;
            val   = fila[0].val;
            base  = fila[0].base;
        end else begin
            // While busy the packer must ignore whatever is presented.
            valid = (fase != 0);
            sel   = 2'($urandom);
            val   = $urandom;
            base  = $urandom;
        end
    endtask

    task automatic modelar();
        if (reset) begin
            modelo_reset();
            return;
        end
        for (int d = 0; d < 2; d++) begin
            if (limpar) begin
                m_erro[d] = 0;
                m_cont[d] = 0;
            end
        end
        case (fase)
            0: if (valid) begin
                cur  = fila.pop_front();
                fase = 1;
            end
            1: begin
                for (int d = 0; d < 2; d++) begin
                    m_acc[d] = cabe_ref(cur.sel, cur.val) && !m_cheia[d];
                    if (m_acc[d]) m_dado[d] = palavra_ref(cur.sel, cur.val, cur.base);
                end
                fase = 2;
            end
            default: begin
                for (int d = 0; d < 2; d++) begin
                    if (m_acc[d]) begin
                        m_posrst[d] = 0;
                        if (m_addr[d] == (32'd1 << larg_end[d]) - 1) m_cheia[d] = 1;
                        else m_addr[d] = m_addr[d] + 1;
                    end else begin
                        m_erro[d] = 1;
                        if (m_cont[d] < 255) m_cont[d] = m_cont[d] + 1;
                    end
                    m_acc[d] = 0;
                end
                fase = 0;
            end
        endcase
    endtask

    task automatic passo();
        @(negedge clock);
        checar_saidas();
        escolher();
        modelar();
    endtask

    task automatic drenar(input string tag, input int limite);
        int n = 0;
        while ((fila.size() != 0 || fase != 0) && n < limite) begin
            passo();
            n++;
        end
        checar({tag, "_pendente"}, 32'(fila.size() + fase), 32'd0);
    endtask

    initial begin
        item_t it;
        valid = 0; limpar = 0; sel = 0; val = 0; base = 0;
        rst_ext = 1; modo_alea = 0; reset = 1;
        cur = '{2'b00, 32'd0, 32'd0, 1'b0, 1'b0};
        modelo_reset();
        repeat (3) passo();
        rst_ext = 0;

        // Directed: boundaries, full memory on the 2-bit unit, clear vs reject, reset mid-check.
        fila.push_back('{2'b00, 32'h0000FFFF, 32'hABC00000, 1'b0, 1'b0});
        fila.push_back('{2'b00, 32'h00010000, 32'h12345678, 1'b0, 1'b0});
        fila.push_back('{2'b00, 32'hFFFF0000, 32'hFFFFFFFF, 1'b0, 1'b0});
        fila.push_back('{2'b01, 32'hFFE00000, 32'h00000000, 1'b0, 1'b0});
        fila.push_back('{2'b10, 32'h0001FFFF, 32'h55555555, 1'b0, 1'b0});
        fila.push_back('{2'b10, 32'hFFFE0000, 32'hAAAAAAAA, 1'b0, 1'b0});
        fila.push_back('{2'b11, 32'h00000005, 32'h0F0F0F0F, 1'b1, 1'b0});
        fila.push_back('{2'b00, 32'h00000007, 32'h11111111, 1'b0, 1'b1});
        fila.push_back('{2'b10, 32'h00020000, 32'h22222222, 1'b0, 1'b0});
        fila.push_back('{2'b01, 32'h001FFFFF, 32'h33333333, 1'b0, 1'b0});
        drenar("dirigido", 100);

        modo_alea = 1;
        for (int i = 0; i < 200; i++) begin
            it.sel   = 2'($urandom);
            it.val   = valor_alea(it.sel);
            it.base  = $urandom;
            it.limpa = ($urandom_range(0, 9) == 0);
            it.rst   = ($urandom_range(0, 49) == 0);
            fila.push_back(it);
        end
        drenar("aleatorio", 2000);

        // Back-to-back without gaps, then saturate the reject counter.
        modo_alea = 0;
        for (int i = 0; i < 30; i++) begin
            it.sel   = 2'($urandom_range(0, 2));
            it.val   = valor_alea(it.sel);
            it.base  = $urandom;
            it.limpa = 0;
            it.rst   = 0;
            fila.push_back(it);
        end
        drenar("seguidos", 200);
        for (int i = 0; i < 300; i++) begin
            fila.push_back('{2'b00, 32'h00100000, 32'hDEADBEEF, 1'b0, 1'b0});
        end
        drenar("saturacao", 1000);
        passo();
        checar("cont_saturado_a", 32'(ia.cont_erros), 32'd255);
        checar("cont_saturado_b", 32'(ib.cont_erros), 32'd255);

        $display("Result: errors=%0d of %0d checks", erros, checks);
        $finish;
    end

endmodule
